// File: rtl/echo_pkg.sv
// Shared constants, FSM encoding and arithmetic helpers for the echo delay line.
package echo_pkg;

    localparam logic [7:0] GAIN_ONE = 8'd128;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_MAC  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic logic [7:0] clamp_gain(input logic [7:0] g);
        return (g > GAIN_ONE) ? GAIN_ONE : g;
    endfunction

    function automatic int unsigned clamp_delay(input int unsigned dn, input int unsigned dmax);
        if (dn == 0) return 1;
        if (dn > dmax) return dmax;
        return dn;
    endfunction

    // Clamp a wide signed value into the two's complement range of width w.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/echo_delay_line_if.sv
// Frame input / output bus of the echo delay line.
interface echo_delay_line_if #(
    parameter int DATA_W = 16,
    parameter int CH     = 2
);
    logic                 in_valid;
    logic [CH*DATA_W-1:0] in_data;
    logic                 out_valid;
    logic [CH*DATA_W-1:0] out_data;
    logic [CH*DATA_W-1:0] out_wet;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_data, out_wet
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_data, out_wet
    );
endinterface

// File: rtl/echo_dpram.sv
// Simple dual-port sample RAM: one write port, one read port with 1-cycle latency.
module echo_dpram #(
    parameter int DATA_W = 16,
    parameter int AW     = 13,
    parameter int WORDS  = 8192
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/echo_delay_line.sv
// Multi-channel delay/echo core: circular frame buffer with feedback and saturated dry+wet mix.
module echo_delay_line
    import echo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int CH     = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    echo_delay_line_if.slave  bus,
    input  logic [ADDR_W-1:0] delay_num,
    input  logic [7:0]        fb_gain,
    input  logic [7:0]        mix_gain,
    input  logic              clr_ovr,
    output logic              busy,
    output logic              overrun
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int AW    = ADDR_W + CH_W;
    localparam int WORDS = DEPTH * CH;
    localparam int FW    = CH * DATA_W;
    localparam int PW    = DATA_W + 9;

    logic [2:0]              state_q, state_d;
    logic [CH_W-1:0]         ch_q;
    logic [ADDR_W-1:0]       wptr_q, fill_q, d_q;
    logic [FW-1:0]           x_q, wet_acc_q, mix_acc_q, out_data_q, out_wet_q;
    logic [7:0]              fb_q, mix_q;
    logic [DATA_W-1:0]       wval_q;
    logic                    out_valid_q, overrun_q, overrun_d;

    logic                    last_ch;
    logic [ADDR_W-1:0]       rptr;
    logic [AW-1:0]           raddr, waddr;
    logic [DATA_W-1:0]       ram_q;
    logic signed [DATA_W-1:0] x_lane, wet;
    logic signed [PW-1:0]    prod_mix, prod_fb;
    logic [DATA_W-1:0]       mix_val, wr_val;

    assign last_ch = (ch_q == CH_W'(CH - 1));
    assign rptr    = wptr_q - d_q;
    assign raddr   = AW'(rptr) * AW'(CH) + AW'(ch_q);
    assign waddr   = AW'(wptr_q) * AW'(CH) + AW'(ch_q);

    echo_dpram #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .WORDS  (WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (state_q == ST_WR),
        .waddr (waddr),
        .wdata (wval_q),
        .re    (state_q == ST_RD),
        .raddr (raddr),
        .rdata (ram_q)
    );

    // Until d frames have been written the buffer slot is stale; treat it as silence.
    assign x_lane   = x_q[ch_q*DATA_W +: DATA_W];
    assign wet      = (d_q > fill_q) ? '0 : ram_q;
    assign prod_mix = PW'(wet) * PW'($signed({1'b0, mix_q}));
    assign prod_fb  = PW'(wet) * PW'($signed({1'b0, fb_q}));
    assign mix_val  = DATA_W'(sat(64'(PW'(x_lane) + (prod_mix >>> 7)), DATA_W));
    assign wr_val   = DATA_W'(sat(64'(PW'(x_lane) + (prod_fb >>> 7)), DATA_W));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid) state_d = ST_RD;
            ST_RD:   state_d = ST_MAC;
            ST_MAC:  state_d = ST_WR;
            ST_WR:   state_d = last_ch ? ST_DONE : ST_RD;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        overrun_d = overrun_q;
        if (clr_ovr) overrun_d = 1'b0;
        if (bus.in_valid && (state_q != ST_IDLE)) overrun_d = 1'b1;
    end

    // Lanes collect in shadow registers so outputs only change together with out_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            wptr_q      <= '0;
            fill_q      <= '0;
            d_q         <= '0;
            x_q         <= '0;
            wet_acc_q   <= '0;
            mix_acc_q   <= '0;
            out_data_q  <= '0;
            out_wet_q   <= '0;
            fb_q        <= '0;
            mix_q       <= '0;
            wval_q      <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            overrun_q   <= overrun_d;
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        x_q   <= bus.in_data;
                        d_q   <= ADDR_W'(clamp_delay(32'(delay_num), DEPTH - 1));
                        fb_q  <= clamp_gain(fb_gain);
                        mix_q <= clamp_gain(mix_gain);
                        ch_q  <= '0;
                    end
                end
                ST_MAC: begin
                    wet_acc_q[ch_q*DATA_W +: DATA_W] <= wet;
                    mix_acc_q[ch_q*DATA_W +: DATA_W] <= mix_val;
                    wval_q <= wr_val;
                end
                ST_WR: begin
                    if (!last_ch) ch_q <= ch_q + 1'b1;
                end
                ST_DONE: begin
                    wptr_q <= wptr_q + 1'b1;
                    if (fill_q != ADDR_W'(DEPTH - 1)) fill_q <= fill_q + 1'b1;
                    out_valid_q <= 1'b1;
                    out_data_q  <= mix_acc_q;
                    out_wet_q   <= wet_acc_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_wet   = out_wet_q;
    assign busy          = (state_q != ST_IDLE);
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_echo_delay_line.sv
// Directed bench for echo_delay_line (CH=2, DATA_W=16, ADDR_W=4).
module tb_echo_delay_line;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] delay_num;
    logic [7:0] fb_gain, mix_gain;
    logic       clr_ovr, busy, overrun;

    always #5 clk = ~clk;

    echo_delay_line_if #(.DATA_W(16), .CH(2)) bus ();

    echo_delay_line #(.DATA_W(16), .ADDR_W(4), .CH(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .delay_num (delay_num),
        .fb_gain   (fb_gain),
        .mix_gain  (mix_gain),
        .clr_ovr   (clr_ovr),
        .busy      (busy),
        .overrun   (overrun)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int lane(input logic [31:0] v, input int k);
        logic signed [15:0] s;
        s = v[k*16 +: 16];
        return int'(s);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        clr_ovr = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic drive_frame(input int x0, input int x1, input int dn, input int fb, input int mix);
        @(negedge clk);
        bus.in_data  = {16'(x1), 16'(x0)};
        delay_num    = 4'(dn);
        fb_gain      = 8'(fb);
        mix_gain     = 8'(mix);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic frame(input int x0, input int x1, input int dn, input int fb, input int mix);
        int lat;
        drive_frame(x0, x1, dn, fb, mix);
        wait_out(lat);
        chk("latency", lat, 7);
    endtask

    initial begin
        int lat;
        int pulses;
        int exp3 [9];
        exp3 = '{0, 0, 1000, 0, 500, 0, 250, 0, 125};

        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        delay_num = '0;
        fb_gain = '0;
        mix_gain = '0;
        clr_ovr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_out_wet", int'(bus.out_wet), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset_n = 1'b1;

        // First frame after reset
        drive_frame(100, -100, 3, 0, 128);
        chk("t1_busy", int'(busy), 1);
        wait_out(lat);
        chk("t1_latency", lat, 7);
        chk("t1_wet0", lane(bus.out_wet, 0), 0);
        chk("t1_wet1", lane(bus.out_wet, 1), 0);
        chk("t1_data0", lane(bus.out_data, 0), 100);
        chk("t1_data1", lane(bus.out_data, 1), -100);
        @(posedge clk); #1;
        chk("t1_pulse_one_cycle", int'(bus.out_valid), 0);
        chk("t1_idle", int'(busy), 0);

        // Impulse, d=3, no feedback
        do_reset();
        frame(1000, 0, 3, 0, 128);
        chk("t2_f0_data0", lane(bus.out_data, 0), 1000);
        chk("t2_f0_wet0", lane(bus.out_wet, 0), 0);
        frame(0, 0, 3, 0, 128);
        chk("t2_f1_wet0", lane(bus.out_wet, 0), 0);
        frame(0, 0, 3, 0, 128);
        chk("t2_f2_wet0", lane(bus.out_wet, 0), 0);
        frame(0, 0, 3, 0, 128);
        chk("t2_f3_wet0", lane(bus.out_wet, 0), 1000);
        chk("t2_f3_data0", lane(bus.out_data, 0), 1000);
        frame(0, 0, 3, 0, 128);
        chk("t2_f4_wet0", lane(bus.out_wet, 0), 0);

        // Feedback 0.5 at d=2
        do_reset();
        for (int f = 0; f < 9; f++) begin
            frame((f == 0) ? 1000 : 0, 0, 2, 64, 128);
            chk("t3_wet0", lane(bus.out_wet, 0), exp3[f]);
            chk("t3_wet1", lane(bus.out_wet, 1), 0);
        end

        // Saturation and gain clamp
        do_reset();
        frame(30000, -30000, 1, 0, 128);
        chk("t4_f0_data0", lane(bus.out_data, 0), 30000);
        frame(30000, -30000, 1, 0, 128);
        chk("t4_sat_hi", lane(bus.out_data, 0), 32767);
        chk("t4_sat_lo", lane(bus.out_data, 1), -32768);
        frame(0, 0, 1, 255, 255);
        chk("t4_mixclamp0", lane(bus.out_data, 0), 30000);
        chk("t4_mixclamp1", lane(bus.out_data, 1), -30000);
        frame(0, 0, 1, 0, 128);
        chk("t4_fbclamp0", lane(bus.out_wet, 0), 30000);
        chk("t4_fbclamp1", lane(bus.out_wet, 1), -30000);

        // Delay clamp, warm-up masking and pointer wrap
        do_reset();
        frame(7, 8, 0, 0, 128);
        chk("t5_f0_wet0", lane(bus.out_wet, 0), 0);
        frame(9, 10, 0, 0, 128);
        chk("t5_d0_wet0", lane(bus.out_wet, 0), 7);
        chk("t5_d0_data1", lane(bus.out_data, 1), 18);
        for (int f = 2; f < 15; f++) begin
            frame(0, 0, 15, 0, 128);
            if (f == 2 || f == 14) begin
                chk("t5_warm_wet0", lane(bus.out_wet, 0), 0);
                chk("t5_warm_wet1", lane(bus.out_wet, 1), 0);
            end
        end
        frame(0, 0, 15, 0, 128);
        chk("t5_f15_wet0", lane(bus.out_wet, 0), 7);
        chk("t5_f15_wet1", lane(bus.out_wet, 1), 8);
        frame(0, 0, 15, 0, 128);
        chk("t5_wrap_wet0", lane(bus.out_wet, 0), 9);

        // Overrun: second strobe two cycles after acceptance is dropped
        do_reset();
        drive_frame(11, 22, 1, 0, 128);
        @(negedge clk);
        bus.in_data = {16'd99, 16'd99};
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out(lat);
        chk("t6_done", int'(lat > 0), 1);
        chk("t6_overrun_set", int'(overrun), 1);
        chk("t6_data0", lane(bus.out_data, 0), 11);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) pulses++;
        end
        chk("t6_no_extra_frame", pulses, 0);
        // Clear and new overrun in the same cycle: set wins
        drive_frame(0, 0, 1, 0, 128);
        @(negedge clk);
        clr_ovr = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        bus.in_valid = 1'b0;
        wait_out(lat);
        chk("t6_wptr_wet0", lane(bus.out_wet, 0), 11);
        chk("t6_wptr_wet1", lane(bus.out_wet, 1), 22);
        chk("t6_set_wins", int'(overrun), 1);
        @(negedge clk);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("t6_cleared", int'(overrun), 0);

        // Reset in the middle of a frame
        drive_frame(5, 5, 1, 0, 128);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_valid", int'(bus.out_valid), 0);
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) pulses++;
        end
        chk("t6_abandoned", pulses, 0);
        frame(13, -13, 1, 0, 128);
        chk("t6_fill_reset_wet0", lane(bus.out_wet, 0), 0);
        chk("t6_fill_reset_data1", lane(bus.out_data, 1), -13);
        frame(0, 0, 1, 0, 128);
        chk("t6_after_rst_wet0", lane(bus.out_wet, 0), 13);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
